// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue stage: op encodings,
// FSM state enum and small op-decode helpers.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Bit 0 clear marks the signed variants (DIV, REM).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation; yields operand magnitudes at accept
// and re-applies the result sign at capture.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    result_o = value_i;
    if (negate_i) begin
      result_o = ~value_i + WIDTH'(1);
    end else begin
      result_o = value_i;
    end
  end

endmodule

// File: rtl/div_issue_stage.sv
// Issue/retire stage around an external unsigned combinational divider:
// accepts signed/unsigned DIV/REM, resolves special cases locally, holds
// operands for a settle window and returns a sign-corrected result.
module div_issue_stage
  import div_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_dbz,
  output logic             rsp_ovf
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL    = {WIDTH{1'b0}};

  div_state_t       state_q, state_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_res_q, neg_res_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] core_dividend_q, core_dividend_d;
  logic [WIDTH-1:0] core_divisor_q, core_divisor_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             signed_op_s;
  logic             req_rem_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic             b_zero_s;
  logic             ovf_s;
  logic [WIDTH-1:0] core_raw_s;
  logic [WIDTH-1:0] core_fixed_s;

  assign signed_op_s = op_is_signed(req_op);
  assign req_rem_s   = op_is_rem(req_op);
  assign a_neg_s     = signed_op_s & req_a[WIDTH-1];
  assign b_neg_s     = signed_op_s & req_b[WIDTH-1];
  assign b_zero_s    = (req_b == ZERO_VAL);
  assign ovf_s       = signed_op_s & (req_a == MIN_VAL) & (req_b == ALL_ONES);
  assign core_raw_s  = is_rem_q ? core_remainder : core_quotient;

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
    .value_i  (req_a),
    .negate_i (a_neg_s),
    .result_o (mag_a_s)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
    .value_i  (req_b),
    .negate_i (b_neg_s),
    .result_o (mag_b_s)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_res (
    .value_i  (core_raw_s),
    .negate_i (neg_res_q),
    .result_o (core_fixed_s)
  );

  // Next-state and datapath update for the IDLE/EXEC/DONE sequence.
  always_comb begin
    state_d         = state_q;
    is_rem_d        = is_rem_q;
    neg_res_d       = neg_res_q;
    cnt_d           = cnt_q;
    core_dividend_d = core_dividend_q;
    core_divisor_d  = core_divisor_q;
    rsp_data_d      = rsp_data_q;
    rsp_dbz_d       = rsp_dbz_q;
    rsp_ovf_d       = rsp_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rsp_dbz_d = 1'b0;
          rsp_ovf_d = 1'b0;
          if (b_zero_s) begin
            rsp_dbz_d  = 1'b1;
            rsp_data_d = req_rem_s ? req_a : ALL_ONES;
            state_d    = ST_DONE;
          end else if (ovf_s) begin
            rsp_ovf_d  = 1'b1;
            rsp_data_d = req_rem_s ? ZERO_VAL : MIN_VAL;
            state_d    = ST_DONE;
          end else begin
            // Remainder takes the dividend's sign; quotient the sign product.
            is_rem_d        = req_rem_s;
            neg_res_d       = req_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
            core_dividend_d = mag_a_s;
            core_divisor_d  = mag_b_s;
            cnt_d           = SETTLE_LOAD;
            state_d         = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = core_fixed_s;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      is_rem_q        <= 1'b0;
      neg_res_q       <= 1'b0;
      cnt_q           <= 4'd0;
      core_dividend_q <= ZERO_VAL;
      core_divisor_q  <= ZERO_VAL;
      rsp_data_q      <= ZERO_VAL;
      rsp_dbz_q       <= 1'b0;
      rsp_ovf_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_rem_q        <= is_rem_d;
      neg_res_q       <= neg_res_d;
      cnt_q           <= cnt_d;
      core_dividend_q <= core_dividend_d;
      core_divisor_q  <= core_divisor_d;
      rsp_data_q      <= rsp_data_d;
      rsp_dbz_q       <= rsp_dbz_d;
      rsp_ovf_q       <= rsp_ovf_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = (state_q == ST_DONE);
  assign core_dividend = core_dividend_q;
  assign core_divisor  = core_divisor_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign rsp_ovf       = rsp_ovf_q;

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed self-checking bench for div_issue_stage with a behavioural
// unsigned divide core beside it.
module tb_div_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic [31:0] core_quotient;
  logic [31:0] core_remainder;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_dbz;
  logic        rsp_ovf;

  int n_checks;
  int n_fail;

  div_issue_stage #(.WIDTH(32), .SETTLE_CYCLES(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .core_dividend  (core_dividend),
    .core_divisor   (core_divisor),
    .core_quotient  (core_quotient),
    .core_remainder (core_remainder),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_dbz        (rsp_dbz),
    .rsp_ovf        (rsp_ovf)
  );

  assign core_quotient  = (core_divisor == 32'd0) ? 32'hFFFF_FFFF : core_dividend / core_divisor;
  assign core_remainder = (core_divisor == 32'd0) ? core_dividend : core_dividend % core_divisor;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request, return cycles from accept edge to rsp_valid (-1 on timeout)
  // and the core inputs seen in the cycle after accept.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] cd, output logic [31:0] cs);
    int w;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cd = core_dividend; cs = core_divisor;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic rsp_handshake;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_dbz, rsp_ovf} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, expected 1000", {req_ready, rsp_valid, rsp_dbz, rsp_ovf});
    end
    n_checks++;
    if ({rsp_data, core_dividend, core_divisor} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h, expected zeros", rsp_data, core_dividend, core_divisor);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu;
    int lat; logic [31:0] cd, cs;
    do_req(2'b01, 32'd100, 32'd7, lat, cd, cs);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL divu_latency: got %0d, expected 2", lat); end
    n_checks++;
    if (rsp_data !== 32'd14) begin n_fail++; $display("FAIL divu_data: got %h, expected %h", rsp_data, 32'd14); end
    n_checks++;
    if ({rsp_dbz, rsp_ovf} !== 2'b00) begin n_fail++; $display("FAIL divu_flags: got %b, expected 00", {rsp_dbz, rsp_ovf}); end
    rsp_handshake();
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL divu_release: got %b, expected 10", {req_ready, rsp_valid}); end
  endtask

  task automatic test_signed;
    int lat; logic [31:0] cd, cs;
    do_req(2'b00, 32'hFFFF_FF9C, 32'd7, lat, cd, cs);
    n_checks++;
    if ({cd, cs} !== {32'd100, 32'd7}) begin n_fail++; $display("FAIL div_core_in: got %h %h, expected 64 7", cd, cs); end
    n_checks++;
    if (rsp_data !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_neg_a: got %h, expected fffffff2", rsp_data); end
    rsp_handshake();
    do_req(2'b10, 32'hFFFF_FF9C, 32'd7, lat, cd, cs);
    n_checks++;
    if (rsp_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_neg_a: got %h, expected fffffffe", rsp_data); end
    rsp_handshake();
    do_req(2'b00, 32'd100, 32'hFFFF_FFF9, lat, cd, cs);
    n_checks++;
    if (rsp_data !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_neg_b: got %h, expected fffffff2", rsp_data); end
    rsp_handshake();
    do_req(2'b10, 32'd100, 32'hFFFF_FFF9, lat, cd, cs);
    n_checks++;
    if (rsp_data !== 32'd2) begin n_fail++; $display("FAIL rem_neg_b: got %h, expected 2", rsp_data); end
    rsp_handshake();
    do_req(2'b11, 32'hFFFF_FF9C, 32'd7, lat, cd, cs);
    n_checks++;
    if (rsp_data !== 32'd2) begin n_fail++; $display("FAIL remu_big: got %h, expected 2", rsp_data); end
    rsp_handshake();
  endtask

  task automatic test_dbz;
    int lat; logic [31:0] cd, cs;
    logic [31:0] prev_cd;
    prev_cd = core_dividend;
    do_req(2'b00, 32'd5, 32'd0, lat, cd, cs);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d, expected 1", lat); end
    n_checks++;
    if ({rsp_dbz, rsp_ovf, rsp_data} !== {2'b10, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL dbz_div: got %b %h, expected 10 ffffffff", {rsp_dbz, rsp_ovf}, rsp_data);
    end
    n_checks++;
    if (cd !== prev_cd) begin n_fail++; $display("FAIL dbz_core_hold: got %h, expected %h", cd, prev_cd); end
    rsp_handshake();
    do_req(2'b10, 32'd5, 32'd0, lat, cd, cs);
    n_checks++;
    if ({rsp_dbz, rsp_data} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL dbz_rem: got %b %h, expected 1 5", rsp_dbz, rsp_data); end
    rsp_handshake();
  endtask

  task automatic test_ovf;
    int lat; logic [31:0] cd, cs;
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, lat, cd, cs);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL ovf_latency: got %0d, expected 1", lat); end
    n_checks++;
    if ({rsp_dbz, rsp_ovf, rsp_data} !== {2'b01, 32'h8000_0000}) begin
      n_fail++; $display("FAIL ovf_div: got %b %h, expected 01 80000000", {rsp_dbz, rsp_ovf}, rsp_data);
    end
    rsp_handshake();
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, cd, cs);
    n_checks++;
    if ({rsp_ovf, rsp_data} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL ovf_rem: got %b %h, expected 1 0", rsp_ovf, rsp_data); end
    rsp_handshake();
    do_req(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat, cd, cs);
    n_checks++;
    if ({rsp_ovf, rsp_data} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL divu_no_ovf: got %b %h, expected 0 0", rsp_ovf, rsp_data); end
    rsp_handshake();
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] cd, cs;
    do_req(2'b01, 32'd1000, 32'd10, lat, cd, cs);
    req_op = 2'b01; req_a = 32'd81; req_b = 32'd9; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({rsp_valid, req_ready, rsp_data} !== {2'b10, 32'd100}) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %b %h, expected 10 64", i, {rsp_valid, req_ready}, rsp_data);
      end
      @(posedge clk); #1;
    end
    rsp_handshake();
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle: got %b, expected 10", {req_ready, rsp_valid}); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_exec: got %b, expected 00", {req_ready, rsp_valid}); end
    @(posedge clk); #1;
    n_checks++;
    if ({rsp_valid, rsp_data} !== {1'b1, 32'd9}) begin n_fail++; $display("FAIL b2b_data: got %b %h, expected 1 9", rsp_valid, rsp_data); end
    rsp_handshake();
  endtask

  task automatic test_reset_mid_exec;
    int lat; logic [31:0] cd, cs;
    req_op = 2'b01; req_a = 32'd50; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if ({req_ready, rsp_valid, core_dividend} !== {2'b00, 32'd50}) begin
      n_fail++; $display("FAIL abort_in_exec: got %b %h, expected 00 32", {req_ready, rsp_valid}, core_dividend);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_dbz, rsp_ovf, rsp_data, core_dividend, core_divisor} !== {4'b1000, 96'd0}) begin
      n_fail++; $display("FAIL abort_reset_vals: got %b %h %h %h, expected 1000 zeros",
                        {req_ready, rsp_valid, rsp_dbz, rsp_ovf}, rsp_data, core_dividend, core_divisor);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_stale%0d: got %b, expected 0", i, rsp_valid); end
    end
    do_req(2'b01, 32'd9, 32'd3, lat, cd, cs);
    n_checks++;
    if ({lat == 2, rsp_data} !== {1'b1, 32'd3}) begin n_fail++; $display("FAIL post_abort: got lat %0d data %h, expected 2 3", lat, rsp_data); end
    rsp_handshake();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_divu();
    test_signed();
    test_dbz();
    test_ovf();
    test_back_to_back();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_stage.md
# div_issue_stage

Sequential front/back end for the team's 32-bit unsigned combinational restoring divide core. Accepts signed or unsigned DIV/REM requests over a valid/ready handshake and registers operand magnitudes to the core. Holds them for a configurable settle window, then captures and sign-corrects the core result. Divide-by-zero and signed overflow are resolved locally without using the core, and the result is presented on a valid/ready response port.

## Interface
- `WIDTH`, 32: operand and result width; must match the core.
- `SETTLE_CYCLES`, 1: cycles operands are held stable before capture (multicycle path to core); legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: stage can accept a request.
- `req_op` in 2: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- `req_a` in WIDTH: dividend.
- `req_b` in WIDTH: divisor.
- `core_dividend` out WIDTH: unsigned dividend to core.
- `core_divisor` out WIDTH: unsigned divisor to core.
- `core_quotient` in WIDTH: core quotient.
- `core_remainder` in WIDTH: core remainder.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_data` out WIDTH: quotient or remainder per op.
- `rsp_dbz` out 1: divisor was zero.
- `rsp_ovf` out 1: signed overflow (MIN / -1).

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch op, sign flags and magnitudes.
  - Go to EXEC, or directly to DONE on a special case.
- Signed ops (DIV, REM):
  - Magnitude = two's-complement negation when MSB is set.
  - 0x8000_0000 maps to 0x8000_0000 unsigned, which is correct.
  - Unsigned ops pass operands unchanged.
- Special cases, decided in IDLE at accept and never sent to the core:
  - b == 0: `rsp_dbz`=1. DIV/DIVU data = all ones. REM/REMU data = `req_a` unchanged.
  - Signed op with a == MIN and b == -1: `rsp_ovf`=1. DIV data = MIN; REM data = 0.
- EXEC:
  - `core_dividend` and `core_divisor` are driven from registers and held constant.
  - A 4-bit counter loads `SETTLE_CYCLES-1` and decrements.
  - At 0, capture the core result and go to DONE.
- Capture:
  - Quotient is negated when the signs of a and b differ (signed DIV only).
  - Remainder is negated when a was negative (signed REM only).
  - Result is registered into `rsp_data`.
- DONE:
  - `rsp_valid` = 1, with `rsp_data`, `rsp_dbz` and `rsp_ovf` stable.
  - On `rsp_ready`, go to IDLE.
- `req_ready` is 0 in EXEC and DONE; one request is in flight at a time.
- Core outputs are ignored outside the capture cycle. Core inputs hold their last value outside EXEC, with no toggling.

## Timing
- Reset values: state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_data`=0; `rsp_dbz`=0; `rsp_ovf`=0; `core_dividend`=0; `core_divisor`=0; settle counter = 0.
- Normal op, accepted at edge T:
  - EXEC for cycles T+1 .. T+SETTLE_CYCLES.
  - `rsp_valid` high from cycle T+SETTLE_CYCLES+1.
- Special case accepted at edge T: `rsp_valid` high from cycle T+1.
- With `rsp_ready` held high, the next request is accepted at the cycle after the response handshake. Minimum period is SETTLE_CYCLES+2 cycles.
- Response is held while `rsp_ready`=0 for an unbounded time; `rsp_valid` never drops without a handshake.
- `req_valid` in EXEC or DONE is ignored and not lost: the requester must hold it per valid/ready rules.
- Asynchronous reset mid-EXEC or mid-DONE aborts the operation immediately. Outputs go to reset values, and no response is produced for the aborted request.

## Structure
- Shared package `div_pkg`:
  - op encoding constants `OP_DIV`, `OP_DIVU`, `OP_REM`, `OP_REMU`;
  - state enum `div_state_t`;
  - constant `DIV_WIDTH`=32.
- One natural sub-module: `div_sign_fix`, combinational magnitude/negation helper used at both accept and capture.
- The unsigned divide core is instantiated beside this block at the next level up, not inside it.

## Test plan
- DIVU, a=100, b=7, SETTLE_CYCLES=1:
  - `rsp_data`=14, flags 0;
  - `rsp_valid` rises 2 cycles after accept.
- DIV, a=-100 (0xFFFF_FF9C), b=7:
  - core sees 100 and 7;
  - `rsp_data`=0xFFFF_FFF2 (-14).
- REM, a=-100, b=7: `rsp_data`=0xFFFF_FFFE (-2).
- DIV and REM with a=5, b=0:
  - `rsp_dbz`=1;
  - DIV data = 0xFFFF_FFFF, REM data = 5;
  - `rsp_valid` 1 cycle after accept, no EXEC.
- DIV, a=0x8000_0000, b=0xFFFF_FFFF: `rsp_ovf`=1, data = 0x8000_0000; the REM variant gives data = 0.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 10 cycles: response stable and `req_ready`=0 throughout.
  - Assert `rst_n`=0 mid-EXEC: all outputs return to reset values, and no stale response appears after release.
